// File: rtl/reg_writeback_queue_pkg.sv
// Shared widths, the queued entry type and the youngest-match search used by
// both read ports of the writeback queue.
package reg_writeback_queue_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;
    localparam int DEPTH      = 4;
    localparam int PTR_WIDTH  = 2;
    localparam int CNT_WIDTH  = PTR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic                  hit;
        logic [DATA_WIDTH-1:0] data;
    } fwd_t;

    // Valid entries are contiguous from head, so scanning oldest to youngest
    // and letting later matches overwrite leaves the youngest match.
    function automatic fwd_t youngest_match(
        input wb_entry_t [DEPTH-1:0] entries,
        input logic [DEPTH-1:0]      valid,
        input logic [PTR_WIDTH-1:0]  head,
        input logic [ADDR_WIDTH-1:0] addr
    );
        fwd_t                 res;
        logic [PTR_WIDTH-1:0] idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_WIDTH'(k);
            if (valid[idx] && (entries[idx].rd == addr) && (addr != ZERO_REG)) begin
                res.hit  = 1'b1;
                res.data = entries[idx].data;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_writeback_queue_wb_entry_fifo.sv
// Circular buffer of writeback entries: head/tail/count plus per-slot valid
// bits, with every slot exposed so the parent can search for hazards.
module wb_entry_fifo
    import reg_writeback_queue_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t [DEPTH-1:0]      entries,
    output logic [DEPTH-1:0]           valid,
    output logic [PTR_WIDTH-1:0]       head,
    output logic [CNT_WIDTH-1:0]       count
);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_WIDTH-1:0]  head_q, head_d;
    logic [PTR_WIDTH-1:0]  tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    // The parent only pushes when not full and only pops when not empty, so
    // head and tail never address the same slot in one cycle.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail_q]   = push_entry;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign entries = mem_q;
    assign valid   = valid_q;
    assign head    = head_q;
    assign count   = count_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback queue in front of the register file write port, with a pending
// register mask and youngest-value forwarding for two decode read ports.
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [ADDR_WIDTH-1:0] inRd,
    input  logic [DATA_WIDTH-1:0] inData,
    input  logic                  drainEn,
    output logic                  RegWr,
    output logic [ADDR_WIDTH-1:0] Rw,
    output logic [DATA_WIDTH-1:0] busW,
    input  logic [ADDR_WIDTH-1:0] Ra,
    input  logic [ADDR_WIDTH-1:0] Rb,
    output logic                  hazA,
    output logic                  hazB,
    output logic [DATA_WIDTH-1:0] fwdA,
    output logic [DATA_WIDTH-1:0] fwdB,
    output logic [NUM_REGS-1:0]   pending
);

    // Handshake: a transfer happens at a rising edge where inValid && inReady.
    // inReady is a function of registered occupancy only, never of inValid or
    // of a pop in the same cycle.

    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [PTR_WIDTH-1:0]  head;
    logic [CNT_WIDTH-1:0]  count;
    logic                  push;
    logic                  has_entry;
    wb_entry_t             push_entry;
    fwd_t                  fwd_a;
    fwd_t                  fwd_b;

    assign has_entry  = (count != '0);
    assign inReady    = !reset && (count < CNT_WIDTH'(DEPTH));
    // Writes to r0 complete the handshake but are dropped.
    assign push       = inValid && inReady && (inRd != ZERO_REG);
    assign push_entry = '{rd: inRd, data: inData};

    assign RegWr = drainEn && has_entry;
    assign Rw    = has_entry ? entries[head].rd   : '0;
    assign busW  = has_entry ? entries[head].data : '0;

    wb_entry_fifo u_fifo (
        .clk        (clk),
        .rst        (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (RegWr),
        .entries    (entries),
        .valid      (valid),
        .head       (head),
        .count      (count)
    );

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                pending[entries[i].rd] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    assign fwd_a = youngest_match(entries, valid, head, Ra);
    assign fwd_b = youngest_match(entries, valid, head, Rb);

    assign hazA = fwd_a.hit;
    assign fwdA = fwd_a.data;
    assign hazB = fwd_b.hit;
    assign fwdB = fwd_b.data;

endmodule
